mod_sub_256: RTL



---
 rtl/ecdsa_pkg.sv | 20 ++
 rtl/limb_addsub_64.sv | 42 ++++
 rtl/mod_sub_256.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/ecdsa_pkg.sv
// Shared field-arithmetic definitions for the ECDSA datapath: widths,
// field/limb types and the secp256k1 modulus.
package ecdsa_pkg;

  localparam int unsigned FIELD_W = 256;
  localparam int unsigned LIMB_W  = 64;
  localparam int unsigned N_LIMBS = 4;

  typedef logic [FIELD_W-1:0] felem_t;
  typedef logic [LIMB_W-1:0]  limb_t;

  localparam felem_t SECP256K1_P =
    256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;

  // Limb idx (0 = least significant) of the modulus.
  function automatic limb_t p_limb(input int unsigned idx);
    return SECP256K1_P[LIMB_W*idx +: LIMB_W];
  endfunction

endpackage

// File: rtl/limb_addsub_64.sv
// Registered 64-bit adder/subtractor with carry/borrow in and out.
//   SUB=1 : o_r = i_x - i_y - i_c, o_c = borrow out
//   SUB=0 : o_r = i_x + i_y + i_c, o_c = carry out
// Ports: clk, rst_n (async active-low), i_en (register enable),
//        i_x, i_y, i_c (operands, chain in), o_r, o_c (registered result, chain out).
module limb_addsub_64
  import ecdsa_pkg::*;
#(
  parameter bit SUB = 1'b0
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  i_en,
  input  limb_t i_x,
  input  limb_t i_y,
  input  logic  i_c,
  output limb_t o_r,
  output logic  o_c
);

  localparam int unsigned EXT_W = LIMB_W + 1;

  logic [EXT_W-1:0] w_res;

  // One extra bit captures the carry, or the borrow as a wrap into bit 64.
  always_comb begin
    w_res = '0;
    if (SUB) w_res = {1'b0, i_x} - {1'b0, i_y} - EXT_W'(i_c);
    else     w_res = {1'b0, i_x} + {1'b0, i_y} + EXT_W'(i_c);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_r <= '0;
      o_c <= 1'b0;
    end else if (i_en) begin
      o_r <= w_res[LIMB_W-1:0];
      o_c <= w_res[LIMB_W];
    end
  end

endmodule

// File: rtl/mod_sub_256.sv
// Pipelined 256-bit modular subtractor: s = (a - b) mod P (secp256k1).
// Stages 1-4 subtract one limb each with a registered borrow chain; stages
// 5-8 add (bf ? P : 0) one limb each with a registered carry chain; a final
// output register holds s/borrow. Whole pipe advances on adv = ~valid_out | ready_in.
// Ports: clk, reset (async active-low), a, b, valid_in, ready_out (combinational),
//        s, borrow (raw borrow of a-b), valid_out, ready_in.
// Optional: define ECDSA_SUB_TAG_EN to add TAG_W, tag_in and tag_out, a tag
//           carried alongside each operand pair.
module mod_sub_256
  import ecdsa_pkg::*;
`ifdef ECDSA_SUB_TAG_EN
#(
  parameter int unsigned TAG_W = 4
)
`endif
(
  input  logic               clk,
  input  logic               reset,
  input  logic [FIELD_W-1:0] a,
  input  logic [FIELD_W-1:0] b,
  input  logic               valid_in,
  output logic               ready_out,
  output logic [FIELD_W-1:0] s,
  output logic               borrow,
  output logic               valid_out,
  input  logic               ready_in
`ifdef ECDSA_SUB_TAG_EN
  ,
  input  logic [TAG_W-1:0]   tag_in,
  output logic [TAG_W-1:0]   tag_out
`endif
);

  localparam int unsigned N_STAGES = 2 * N_LIMBS;

  logic w_adv;

  limb_t w_x  [N_STAGES];
  limb_t w_y  [N_STAGES];
  logic  w_ci [N_STAGES];
  limb_t w_ru [N_STAGES];
  logic  w_co [N_STAGES];

  // Operand skew: each stage keeps only the limbs still to be consumed.
  logic [3*LIMB_W-1:0] r_a1, r_b1;
  logic [2*LIMB_W-1:0] r_a2, r_b2;
  logic [LIMB_W-1:0]   r_a3, r_b3;
  // Low difference limbs already produced, delayed to stage 4.
  logic [LIMB_W-1:0]   r_dl2;
  logic [2*LIMB_W-1:0] r_dl3;
  logic [3*LIMB_W-1:0] r_dl4;
  // Upper difference limbs and final borrow travelling through the correction half.
  logic [3*LIMB_W-1:0] r_d5;
  logic [2*LIMB_W-1:0] r_d6;
  logic [LIMB_W-1:0]   r_d7;
  logic                r_bf5, r_bf6, r_bf7, r_bf8;
  // Low corrected limbs already produced, delayed to stage 8.
  logic [LIMB_W-1:0]   r_sl6;
  logic [2*LIMB_W-1:0] r_sl7;
  logic [3*LIMB_W-1:0] r_sl8;

  logic [N_STAGES-1:0] r_v;
  logic [FIELD_W-1:0]  r_s;
  logic                r_borrow;
  logic                r_valid_out;

  logic [FIELD_W-1:0]  w_d;
  logic                w_unused_carry;

  assign w_adv     = ~r_valid_out | ready_in;
  assign ready_out = w_adv;

  assign s         = r_s;
  assign borrow    = r_borrow;
  assign valid_out = r_valid_out;

  // Stage-4 difference and final borrow.
  assign w_d = {w_ru[3], r_dl4};

  // Subtract half: limb i of a-b with borrow from limb i-1.
  assign w_x[0]  = a[LIMB_W-1:0];
  assign w_y[0]  = b[LIMB_W-1:0];
  assign w_ci[0] = 1'b0;
  assign w_x[1]  = r_a1[LIMB_W-1:0];
  assign w_y[1]  = r_b1[LIMB_W-1:0];
  assign w_ci[1] = w_co[0];
  assign w_x[2]  = r_a2[LIMB_W-1:0];
  assign w_y[2]  = r_b2[LIMB_W-1:0];
  assign w_ci[2] = w_co[1];
  assign w_x[3]  = r_a3;
  assign w_y[3]  = r_b3;
  assign w_ci[3] = w_co[2];

  // Correction half: limb j of d + (bf ? P : 0) with carry from limb j-1.
  assign w_x[4]  = w_d[LIMB_W-1:0];
  assign w_y[4]  = w_co[3] ? p_limb(0) : '0;
  assign w_ci[4] = 1'b0;
  assign w_x[5]  = r_d5[LIMB_W-1:0];
  assign w_y[5]  = r_bf5 ? p_limb(1) : '0;
  assign w_ci[5] = w_co[4];
  assign w_x[6]  = r_d6[LIMB_W-1:0];
  assign w_y[6]  = r_bf6 ? p_limb(2) : '0;
  assign w_ci[6] = w_co[5];
  assign w_x[7]  = r_d7;
  assign w_y[7]  = r_bf7 ? p_limb(3) : '0;
  assign w_ci[7] = w_co[6];

  // Result is mod 2^256, so the top carry is dropped.
  assign w_unused_carry = w_co[7];

  for (genvar gi = 0; gi < N_STAGES; gi++) begin : g_limb
    limb_addsub_64 #(
      .SUB (gi < N_LIMBS)
    ) u_limb (
      .clk   (clk),
      .rst_n (reset),
      .i_en  (w_adv),
      .i_x   (w_x[gi]),
      .i_y   (w_y[gi]),
      .i_c   (w_ci[gi]),
      .o_r   (w_ru[gi]),
      .o_c   (w_co[gi])
    );
  end

  // Pipeline side registers and output register, all under the global enable.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_v         <= '0;
      r_a1        <= '0;
      r_b1        <= '0;
      r_a2        <= '0;
      r_b2        <= '0;
      r_a3        <= '0;
      r_b3        <= '0;
      r_dl2       <= '0;
      r_dl3       <= '0;
      r_dl4       <= '0;
      r_d5        <= '0;
      r_d6        <= '0;
      r_d7        <= '0;
      r_bf5       <= 1'b0;
      r_bf6       <= 1'b0;
      r_bf7       <= 1'b0;
      r_bf8       <= 1'b0;
      r_sl6       <= '0;
      r_sl7       <= '0;
      r_sl8       <= '0;
      r_s         <= '0;
      r_borrow    <= 1'b0;
      r_valid_out <= 1'b0;
    end else if (w_adv) begin
      r_v         <= {r_v[N_STAGES-2:0], valid_in};
      r_a1        <= a[FIELD_W-1:LIMB_W];
      r_b1        <= b[FIELD_W-1:LIMB_W];
      r_a2        <= r_a1[3*LIMB_W-1:LIMB_W];
      r_b2        <= r_b1[3*LIMB_W-1:LIMB_W];
      r_a3        <= r_a2[2*LIMB_W-1:LIMB_W];
      r_b3        <= r_b2[2*LIMB_W-1:LIMB_W];
      r_dl2       <= w_ru[0];
      r_dl3       <= {w_ru[1], r_dl2};
      r_dl4       <= {w_ru[2], r_dl3};
      r_d5        <= w_d[FIELD_W-1:LIMB_W];
      r_d6        <= r_d5[3*LIMB_W-1:LIMB_W];
      r_d7        <= r_d6[2*LIMB_W-1:LIMB_W];
      r_bf5       <= w_co[3];
      r_bf6       <= r_bf5;
      r_bf7       <= r_bf6;
      r_bf8       <= r_bf7;
      r_sl6       <= w_ru[4];
      r_sl7       <= {w_ru[5], r_sl6};
      r_sl8       <= {w_ru[6], r_sl7};
      r_s         <= {w_ru[7], r_sl8};
      r_borrow    <= r_bf8;
      r_valid_out <= r_v[N_STAGES-1];
    end
  end

`ifdef ECDSA_SUB_TAG_EN
  logic [TAG_W-1:0] r_tag [N_STAGES];
  logic [TAG_W-1:0] r_tag_out;

  assign tag_out = r_tag_out;

  // Tag shift register matching the data pipeline depth.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N_STAGES; i++) r_tag[i] <= '0;
      r_tag_out <= '0;
    end else if (w_adv) begin
      r_tag[0] <= tag_in;
      for (int i = 1; i < N_STAGES; i++) r_tag[i] <= r_tag[i-1];
      r_tag_out <= r_tag[N_STAGES-1];
    end
  end
`endif

endmodule
